// File: rtl/udp_tx_pack_pkg.sv
// rtl/udp_tx_pack_pkg.sv - shared constants, state encoding and nibble select for the tx packer
package udp_tx_pack_pkg;

    localparam int PKT_WORDS_DEF  = 16;
    localparam int DEPTH_LOG2_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SEND  = 2'd2
    } pack_state_e;

    // Nibble order is the inverse of the rx 4-to-16 assembler: [11:8],[15:12],[3:0],[7:4]
    function automatic logic [3:0] nibble_sel(input logic [15:0] word, input logic [1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = word[11:8];
            2'd1:    nib = word[15:12];
            2'd2:    nib = word[3:0];
            default: nib = word[7:4];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/udp_tx_pack_word_ram.sv
// rtl/udp_tx_pack_word_ram.sv - simple dual-port word memory, synchronous write, asynchronous read
module udp_tx_pack_word_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              phy_clk_tx,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port; contents are not reset, pointers in the owner define validity
    always_ff @(posedge phy_clk_tx) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/udp_tx_pack.sv
// rtl/udp_tx_pack.sv - buffers 16-bit words and serves fixed-size packets as MII nibbles
module udp_tx_pack
    import udp_tx_pack_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int PKT_WORDS  = PKT_WORDS_DEF
) (
    input  logic                phy_clk_tx,
    input  logic                rst_n,
    input  logic [15:0]         sys_data,
    input  logic                sys_en,
    input  logic                rd_en,
    output logic [3:0]          tx_nibble,
    output logic                empty,
    output logic                pkt_go,
    output logic                full,
    output logic [DEPTH_LOG2:0] level,
    output logic [7:0]          drop_cnt
);

    localparam int CNT_W = $clog2(4 * PKT_WORDS);
    localparam logic [CNT_W-1:0]      LAST_NIB = CNT_W'(4 * PKT_WORDS - 1);
    localparam logic [DEPTH_LOG2:0]   PKT_LVL  = (DEPTH_LOG2 + 1)'(PKT_WORDS);
    localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);

    pack_state_e           state;
    pack_state_e           state_next;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [1:0]            nib_idx;
    logic [CNT_W-1:0]      pkt_cnt;
    logic [15:0]           rd_word;
    logic                  serve;
    logic                  pop;
    logic                  wr_accept;
    logic                  drop;

    // A nibble is served only while a packet is armed or in flight; the last nibble of a word pops it
    assign serve     = rd_en && ((state == ST_ARMED) || (state == ST_SEND));
    assign pop       = serve && (nib_idx == 2'd3);
    assign full      = (level == FULL_LVL);
    assign wr_accept = sys_en && (!full || pop);
    assign drop      = sys_en && full && !pop;

    udp_tx_pack_word_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (16)
    ) u_word_ram (
        .phy_clk_tx (phy_clk_tx),
        .wr_en      (wr_accept),
        .wr_addr    (wr_ptr),
        .wr_data    (sys_data),
        .rd_addr    (rd_ptr),
        .rd_data    (rd_word)
    );

    // Buffer pointers, occupancy and saturating drop counter
    always_ff @(posedge phy_clk_tx) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            if (wr_accept && !pop) begin
                level <= level + (DEPTH_LOG2 + 1)'(1);
            end else if (pop && !wr_accept) begin
                level <= level - (DEPTH_LOG2 + 1)'(1);
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Packer state register
    always_ff @(posedge phy_clk_tx) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status flags
    always_comb begin
        state_next = state;
        empty      = 1'b0;
        pkt_go     = 1'b0;
        case (state)
            ST_IDLE: begin
                empty = 1'b1;
                if (level >= PKT_LVL) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                pkt_go = 1'b1;
                if (serve) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (serve && (pkt_cnt == LAST_NIB)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Nibble index, per-packet nibble count and registered output nibble
    always_ff @(posedge phy_clk_tx) begin
        if (!rst_n) begin
            nib_idx   <= '0;
            pkt_cnt   <= '0;
            tx_nibble <= '0;
        end else begin
            if (serve) begin
                nib_idx   <= nib_idx + 2'd1;
                tx_nibble <= nibble_sel(rd_word, nib_idx);
            end
            if (state_next == ST_IDLE) begin
                pkt_cnt <= '0;
            end else if (serve) begin
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_pack.sv
// tb/tb_udp_tx_pack.sv - randomized scoreboard bench for udp_tx_pack against a queue-based model
module tb_udp_tx_pack;

    localparam int PKT   = 16;
    localparam int DEPTH = 64;

    logic        phy_clk_tx = 1'b0;
    logic        rst_n      = 1'b0;
    logic [15:0] sys_data   = '0;
    logic        sys_en     = 1'b0;
    logic        rd_en      = 1'b0;
    logic [3:0]  tx_nibble;
    logic        empty;
    logic        pkt_go;
    logic        full;
    logic [6:0]  level;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    udp_tx_pack dut (
        .phy_clk_tx (phy_clk_tx),
        .rst_n      (rst_n),
        .sys_data   (sys_data),
        .sys_en     (sys_en),
        .rd_en      (rd_en),
        .tx_nibble  (tx_nibble),
        .empty      (empty),
        .pkt_go     (pkt_go),
        .full       (full),
        .level      (level),
        .drop_cnt   (drop_cnt)
    );

    always #5 phy_clk_tx = ~phy_clk_tx;

    typedef struct {
        logic [3:0]  nib;
        int          idx;
        logic [15:0] word;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] wq[$];
    int          m_drop = 0;
    int          m_st   = 0;
    int          m_ns   = 0;
    logic [3:0]  m_nib  = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] nib_of(input logic [15:0] w, input int i);
        int sh;
        sh = (i == 0) ? 8 : (i == 1) ? 12 : (i == 2) ? 0 : 4;
        return 4'((w >> sh) & 16'h000F);
    endfunction

    // Reference model: 0 idle, 1 armed, 2 sending; words held in a bounded queue
    always @(posedge phy_clk_tx) begin
        int          lvl_pre;
        int          idx;
        bit          served;
        logic [15:0] w;
        logic [3:0]  n;
        if (!rst_n) begin
            wq.delete();
            m_drop = 0;
            m_st   = 0;
            m_ns   = 0;
            m_nib  = '0;
        end else begin
            lvl_pre = wq.size();
            served  = rd_en && (m_st != 0);
            if (served) begin
                idx   = m_ns % 4;
                w     = wq[0];
                n     = nib_of(w, idx);
                m_nib = n;
                sb.push_back('{nib: n, idx: idx, word: w});
                m_ns++;
                if (idx == 3) void'(wq.pop_front());
            end
            if (sys_en) begin
                if (wq.size() < DEPTH) wq.push_back(sys_data);
                else if (m_drop < 255) m_drop++;
            end
            case (m_st)
                0: if (lvl_pre >= PKT) m_st = 1;
                1: if (served) m_st = 2;
                default: if (served && m_ns == 4 * PKT) begin m_st = 0; m_ns = 0; end
            endcase
        end
    end

    // Monitor: compare flags each cycle, pop served nibbles and reassemble words rx-style
    logic [15:0] asm_word = '0;
    always @(negedge phy_clk_tx) begin
        exp_t e;
        int   sh;
        chk("empty", empty, m_st == 0);
        chk("pkt_go", pkt_go, m_st == 1);
        chk("level", level, wq.size());
        chk("full", full, wq.size() == DEPTH);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("tx_nibble_hold", tx_nibble, m_nib);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("nibble", tx_nibble, e.nib);
            sh = (e.idx == 0) ? 8 : (e.idx == 1) ? 12 : (e.idx == 2) ? 0 : 4;
            if (e.idx == 0) asm_word = '0;
            asm_word[sh +: 4] = tx_nibble;
            if (e.idx == 3) chk("rx_word", asm_word, e.word);
        end
    end

    task automatic cyc(input bit r, input bit se, input logic [15:0] d, input bit re);
        @(negedge phy_clk_tx);
        rst_n    = r;
        sys_en   = se;
        sys_data = d;
        rd_en    = re;
    endtask

    initial begin
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_tx_nibble", tx_nibble, 0);
        chk("rst_pkt_go", pkt_go, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_drop", drop_cnt, 0);

        // single packet of counting words
        for (int i = 0; i < 16; i++) cyc(1, 1, 16'(i), 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("armed_go", pkt_go, 1);
        for (int i = 0; i < 64; i++) cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        chk("pkt1_empty", empty, 1);
        chk("pkt1_level", level, 0);

        // nibble order with a constant word
        for (int i = 0; i < 16; i++) cyc(1, 1, 16'hABCD, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 70; i++) cyc(1, 0, 0, 1);

        // overflow, then write concurrent with pop at full
        for (int i = 0; i < 70; i++) cyc(1, 1, 16'($urandom), 0);
        cyc(1, 0, 0, 0);
        chk("ovf_full", full, 1);
        chk("ovf_drop", drop_cnt, 6);
        chk("ovf_level", level, 64);
        for (int i = 0; i < 4; i++) cyc(1, 1, 16'($urandom), 1);
        cyc(1, 0, 0, 0);
        chk("pop_write_drop", drop_cnt, 9);
        chk("pop_write_level", level, 64);
        for (int i = 0; i < 300; i++) cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        chk("drain_empty", empty, 1);

        // stall with back-to-back packets
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 32; i++) cyc(1, 1, 16'($urandom), 0);
        for (int i = 0; i < 320; i++) cyc(1, 0, 0, i % 2 == 1);
        cyc(1, 0, 0, 0);
        chk("stall_level", level, 0);

        // reset in the middle of a packet
        for (int i = 0; i < 16; i++) cyc(1, 1, 16'($urandom), 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1);
        chk("midrst_nibble", tx_nibble, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_go", pkt_go, 0);
        chk("midrst_level", level, 0);

        // drop counter saturation
        for (int i = 0; i < 364; i++) cyc(1, 1, 16'($urandom), 0);
        cyc(1, 0, 0, 0);
        chk("sat_drop", drop_cnt, 255);
        cyc(0, 0, 0, 0);

        // random traffic with occasional reset
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 499) != 0, $urandom_range(0, 1) == 1, 16'($urandom),
                $urandom_range(0, 9) < 7);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_tx_pack.md
# udp_tx_pack

Transmit-side word-to-nibble packer for the UDP/IP path, in the `phy_clk_tx` domain. Buffers 16-bit system words (`sys_data`/`sys_en`, e.g. camera pixels) and groups them into fixed-size packets. For each packet it raises `pkt_go` toward `udp_send` and serves the payload as 4-bit MII nibbles on `udp_send`'s read requests. Nibble order is the exact inverse of the receive-side 4-bit-to-16-bit assembly, so words survive a loopback unchanged.

## Interface
- `DEPTH_LOG2`, 6: word buffer depth is 2^DEPTH_LOG2 (64 words).
- `PKT_WORDS`, 16: payload words per packet; legal range 1..2^DEPTH_LOG2.
- `phy_clk_tx  in  1`: the block's only clock. All logic is on its rising edge.
- `rst_n  in  1`: reset, synchronous and active-low.
- `sys_data  in  16`: word to buffer.
- `sys_en  in  1`: write strobe for `sys_data`, one word per cycle. There is no backpressure.
- `rd_en  in  1`: nibble read request, driven by `udp_send` `fifo_en`.
- `tx_nibble  out  4`: payload nibble, registered.
- `empty  out  1`: high when no packet is armed or in progress.
- `pkt_go  out  1`: packet ready; ORed into `udp_send` `go`.
- `full  out  1`: word buffer is full.
- `level  out  DEPTH_LOG2+1`: number of words currently buffered.
- `drop_cnt  out  8`: words dropped because the buffer was full. Saturates at 255.

## Operation
- **Word buffer:** circular memory with DEPTH_LOG2-bit write and read pointers. Pointers wrap naturally.
  - `level` increments on an accepted write and decrements on a word pop.
  - A write and a pop in the same cycle leave `level` unchanged.
  - `full` = (`level` == 2^DEPTH_LOG2).
- **Overflow:**
  - `sys_en` while full with no pop that cycle: the word is discarded and `drop_cnt` increments (saturating).
  - `sys_en` while full with a pop that cycle: the word is accepted.
- **State machine:**
  - IDLE: when `level` >= PKT_WORDS, go to ARMED.
  - ARMED: `pkt_go`=1. The first `rd_en` is served and the state moves to SEND.
  - SEND: every `rd_en` is served. When nibble 4*PKT_WORDS-1 is served, go to IDLE.
  - In IDLE, `rd_en` is ignored and `tx_nibble` holds its value.
- **Nibble sequencing:** a 2-bit nibble index walks through the word at `rd_ptr` in this order:
  - idx 0 → [11:8]
  - idx 1 → [15:12]
  - idx 2 → [3:0]
  - idx 3 → [7:4]
  - Serving idx 3 pops the word (`rd_ptr`+1, `level`-1) and wraps the index to 0.
- **Packet counter:** counts nibbles served in the current packet, from 0 to 4*PKT_WORDS-1, and clears on entry to IDLE.
- **Flag outputs:**
  - `empty` = (state == IDLE).
  - `pkt_go` = (state == ARMED).
- **Back-to-back packets:** if `level` >= PKT_WORDS again after a packet ends, ARMED is re-entered on the next cycle.

## Timing
- **Reset:** while `rst_n`=0 at a clock edge, the block enters IDLE and clears both pointers, `level`, the nibble index, the packet counter and `drop_cnt`. Output values under reset:
  - `tx_nibble`=0, `pkt_go`=0, `empty`=1, `full`=0, `level`=0, `drop_cnt`=0.
  - Buffered data is discarded. A reset in the middle of a packet aborts it with no further nibbles.
- **Write latency:** `sys_en` at edge N is reflected in `level` after edge N. `pkt_go` can rise at the earliest one cycle later (IDLE→ARMED).
- **Read latency:** `rd_en` sampled at edge N gives `tx_nibble` valid after edge N, i.e. one cycle. `udp_send` must treat data as trailing `fifo_en` by one cycle.
- **Throughput:** one nibble per cycle while `rd_en` is held. Gaps in `rd_en` stall the sequence with no loss.
- **ARMED→SEND:** the transition happens on the edge that serves the first nibble.
- **End of packet:** `empty` rises one cycle after the last nibble is served. Extra `rd_en` after that is ignored.

## Structure
- **Shared constants** belong in `udp_para.v`: `PKT_WORDS` default, `DEPTH_LOG2` default, state encodings (IDLE=0, ARMED=1, SEND=2).
- **Sub-module:** one natural sub-module, `udp_word_ram`, a simple dual-port memory (synchronous write, asynchronous or registered read). With a registered read, the nibble mux stays aligned so total read latency is still one cycle.
- **Top level:** the packer FSM, pointers, counters and nibble mux.

## Test plan
- **Single packet:** reset, write 16 words 0x0000..0x000F, hold `rd_en` 64 cycles.
  - `pkt_go` goes high; `tx_nibble` runs 0,0,0,0, 0,0,1,0, 0,0,2,0, …
  - `empty` rises after nibble 64; `level`=0.
- **Nibble order:** write 0xABCD ×16.
  - Each 4-nibble group is B,A,D,C.
  - Feeding the nibbles into the receive assembler reproduces 0xABCD.
- **Overflow:** write 70 words with no reads.
  - `full`=1 at 64 words; `drop_cnt`=6; `level`=64.
  - A write in the same cycle as a pop at full is accepted, with `drop_cnt` unchanged.
- **Stall and back-to-back:** write 32 words; toggle `rd_en` 1-on/1-off.
  - 128 nibbles are delivered in order.
  - `pkt_go` re-asserts one cycle after the first packet ends.
- **Reset mid-packet:** assert `rst_n`=0 after 10 nibbles.
  - All outputs return to reset values; subsequent `rd_en` is ignored.
- **Saturation:** 300 writes while full, no reads → `drop_cnt`=255.
